// File: rtl/hht_pkg.sv
// Shared constants and state type for the HHT gather engine.
// The optional bounds check is enabled with HHT_BOUNDS_CHECK_EN (see hht_gather_ctrl).
package hht_pkg;

    localparam logic [4:0] REG_COL_BASE = 5'd6;
    localparam logic [4:0] REG_VAL_BASE = 5'd8;
    localparam logic [4:0] REG_ROW_BASE = 5'd15;
    localparam logic [4:0] REG_MAT_BASE = 5'd9;

    typedef enum logic [1:0] {
        BASE_A,
        BASE_B,
        RUN,
        DONE
    } hht_state_e;

endpackage

// File: rtl/hht_buf.sv
// Circular FIFO holding gathered vector values until the CPU pops them.
// Storage is exposed as 'val' so the CPU data mux can read the head entry.
module hht_buf #(
    parameter  int DEPTH = 9,
    parameter  int WIDTH = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [PTR_W-1:0] head
);

    logic [WIDTH-1:0] val [0:DEPTH-1];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    always_comb begin
        push_ok = push && (count_q != CNT_W'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        head_d  = pop_ok ? next_ptr(head_q) : head_q;
        tail_d  = push_ok ? next_ptr(tail_q) : tail_q;
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Contents need no reset: clearing count already discards them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            val[tail_q] <= push_data;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/hht_gather_ctrl.sv
// HHT gather engine: streams column indices, gathers vector values into a FIFO for the CPU.
// Optional macro HHT_BOUNDS_CHECK_EN: indices >= VEC_LEN push 0 without a vector access.
module hht_gather_ctrl
    import hht_pkg::*;
#(
    parameter int BUF_DEPTH     = 9,
    parameter int HHT_PORT_ADDR = 126,
    parameter int VEC_LEN       = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] base_dat_a,
    input  logic [31:0] base_dat_b,
    output logic [31:0] addr1,
    output logic [31:0] addr2,
    input  logic [31:0] dataIn1,
    input  logic [31:0] dataIn2,
    input  logic        RD,
    input  logic [31:0] csize,
    input  logic [31:0] cpu_addr,
    output logic        hht,
    output logic [4:0]  regaddr1,
    output logic [4:0]  regaddr2,
    output logic [4:0]  rdata,
    output logic [4:0]  adata
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    hht_state_e state_q, state_d;

    logic [31:0] col_base_q;
    logic [31:0] row_base_q;
    logic [31:0] v_base_q;
    logic [31:0] mat_base_q;
    logic [31:0] n_q;
    logic [31:0] issued_q;
    logic [31:0] col_reg_q;
    logic        s2_valid_q;

    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] fifo_head;
    logic [31:0]      occupancy;
    logic [31:0]      push_data;
    logic             pop;
    logic             issue;
    logic             push;
    logic             in_bounds;
    logic             unused_reserved;

    hht_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_buf (
        .clk       (Clk),
        .rst_n     (Rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

`ifdef HHT_BOUNDS_CHECK_EN
    assign in_bounds = (col_reg_q < 32'(VEC_LEN));
`else
    assign in_bounds = 1'b1;
`endif

    // row/mat bases are captured for future kernels but not consumed here.
    assign unused_reserved = ^{row_base_q, mat_base_q, 32'(VEC_LEN)};

    // Slot accounting counts the in-flight stage-2 element; a same-cycle pop frees one.
    always_comb begin
        pop       = RD && (cpu_addr == 32'(HHT_PORT_ADDR)) && hht;
        occupancy = 32'(fifo_count) + 32'(s2_valid_q);
        issue     = (state_q == RUN) && (issued_q < n_q)
                    && (occupancy < (32'(BUF_DEPTH) + 32'(pop)));
        push      = (state_q == RUN) && s2_valid_q;
        addr1     = issue ? (col_base_q + issued_q) : 32'd0;
        addr2     = (push && in_bounds) ? (v_base_q + col_reg_q) : 32'd0;
        push_data = in_bounds ? dataIn2 : 32'd0;
    end

    assign hht   = (fifo_count != '0);
    assign rdata = 5'(fifo_count);
    assign adata = 5'(fifo_head);

    always_comb begin
        state_d  = state_q;
        regaddr1 = REG_COL_BASE;
        regaddr2 = REG_ROW_BASE;
        case (state_q)
            BASE_A: begin
                state_d = BASE_B;
            end
            BASE_B: begin
                regaddr1 = REG_VAL_BASE;
                regaddr2 = REG_MAT_BASE;
                state_d  = (n_q == 32'd0) ? DONE : RUN;
            end
            RUN: begin
                if ((issued_q == n_q) && !s2_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = BASE_A;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= BASE_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col_base_q <= '0;
            row_base_q <= '0;
            v_base_q   <= '0;
            mat_base_q <= '0;
            n_q        <= '0;
            issued_q   <= '0;
            col_reg_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            if (state_q == BASE_A) begin
                col_base_q <= base_dat_a;
                row_base_q <= base_dat_b;
                n_q        <= csize;
            end
            if (state_q == BASE_B) begin
                v_base_q   <= base_dat_a;
                mat_base_q <= base_dat_b;
            end
            s2_valid_q <= issue;
            if (issue) begin
                col_reg_q <= dataIn1;
                issued_q  <= issued_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hht_gather_ctrl.sv
// Scoreboard bench for hht_gather_ctrl: expected address/data streams are queued per run
// and a negedge monitor compares them whenever the DUT issues, gathers or is popped.
module tb_hht_gather_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] base_dat_a;
    logic [31:0] base_dat_b;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic        RD = 1'b0;
    logic [31:0] csize = 32'd0;
    logic [31:0] cpu_addr = 32'd0;
    logic        hht;
    logic [4:0]  regaddr1;
    logic [4:0]  regaddr2;
    logic [4:0]  rdata;
    logic [4:0]  adata;

    // Memory and register-file models
    logic [31:0] colArr [256];
    logic [31:0] vecArr [64];
    logic [31:0] colBase = 32'd0;
    logic [31:0] vBase   = 32'd0;
    logic [31:0] rowBase = 32'd0;
    logic [31:0] matBase = 32'd0;

    // Scoreboard state
    logic [31:0] expA1 [$];
    logic [31:0] expA2 [$];
    logic [31:0] expData [$];
    int modelCount = 0;
    int popCount = 0;
    int checks = 0;
    int fails = 0;

    hht_gather_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .base_dat_a (base_dat_a),
        .base_dat_b (base_dat_b),
        .addr1      (addr1),
        .addr2      (addr2),
        .dataIn1    (dataIn1),
        .dataIn2    (dataIn2),
        .RD         (RD),
        .csize      (csize),
        .cpu_addr   (cpu_addr),
        .hht        (hht),
        .regaddr1   (regaddr1),
        .regaddr2   (regaddr2),
        .rdata      (rdata),
        .adata      (adata)
    );

    always #5 Clk = ~Clk;

    assign dataIn1 = colArr[8'(addr1 - colBase)];
    assign dataIn2 = vecArr[6'(addr2)];
    assign base_dat_a = (regaddr1 == 5'd6) ? colBase :
                        (regaddr1 == 5'd8) ? vBase : 32'hDEAD_0000;
    assign base_dat_b = (regaddr2 == 5'd15) ? rowBase :
                        (regaddr2 == 5'd9) ? matBase : 32'hDEAD_0001;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] headValue();
        return dut.u_buf.val[int'(adata)];
    endfunction

    // The monitor consumes the expected streams whenever the DUT shows activity.
    always @(negedge Clk) begin : monitor
        logic popNow;
        logic pushNow;
        if (Rst) begin
            popNow  = RD && (cpu_addr == 32'd126) && hht;
            pushNow = (addr2 != 32'd0);
            checkOutput("occupancy", {27'd0, rdata}, 32'(modelCount));
            checkOutput("hht_flag", {31'd0, hht}, {31'd0, modelCount != 0});
            if (addr1 != 32'd0) begin
                if (expA1.size() == 0) checkOutput("addr1_extra", addr1, 32'd0);
                else checkOutput("addr1", addr1, expA1.pop_front());
            end
            if (pushNow) begin
                if (expA2.size() == 0) checkOutput("addr2_extra", addr2, 32'd0);
                else checkOutput("addr2", addr2, expA2.pop_front());
            end
            if (popNow) begin
                popCount++;
                if (expData.size() == 0) checkOutput("pop_extra", 32'(popCount), 32'd0);
                else checkOutput("pop_data", headValue(), expData.pop_front());
            end
            modelCount = modelCount + int'(pushNow) - int'(popNow);
            if (modelCount > 9) checkOutput("fifo_overflow", 32'(modelCount), 32'd9);
        end
    end

    // Holds reset, loads a fresh memory image, checks reset outputs, queues the
    // expected streams, then releases reset mid-cycle.
    task automatic applyStimulus(input logic [31:0] cb, input logic [31:0] vb,
                                 input logic [31:0] n, input bit planTable);
        logic [31:0] c;
        Rst = 1'b0;
        expA1.delete();
        expA2.delete();
        expData.delete();
        modelCount = 0;
        popCount   = 0;
        colBase = cb;
        vBase   = vb;
        rowBase = $urandom;
        matBase = $urandom;
        csize   = n;
        for (int i = 0; i < 256; i++) colArr[i] = 32'($urandom_range(0, 15));
        for (int i = 0; i < 64; i++) vecArr[i] = $urandom;
        if (planTable) begin
            colArr[0] = 32'd7;
            colArr[1] = 32'd14;
            colArr[2] = 32'd8;
            vecArr[9]  = 32'd8;
            vecArr[16] = 32'd84;
            vecArr[10] = 32'd54;
        end
        @(posedge Clk);
        #1;
        checkOutput("rst_addr1", addr1, 32'd0);
        checkOutput("rst_addr2", addr2, 32'd0);
        checkOutput("rst_hht", {31'd0, hht}, 32'd0);
        checkOutput("rst_rdata", {27'd0, rdata}, 32'd0);
        checkOutput("rst_adata", {27'd0, adata}, 32'd0);
        checkOutput("rst_regaddr1", {27'd0, regaddr1}, 32'd6);
        checkOutput("rst_regaddr2", {27'd0, regaddr2}, 32'd15);
        for (int i = 0; i < int'(n); i++) begin
            c = colArr[i];
            expA1.push_back(cb + 32'(i));
            expA2.push_back(vb + c);
            expData.push_back(vecArr[6'(vb + c)]);
        end
        @(negedge Clk);
        #1 Rst = 1'b1;
    endtask

    // Drains with continuous pops and confirms the engine ends idle with every element delivered.
    task automatic finishRun(input int n, input int budget);
        bit drained = 1'b0;
        @(posedge Clk);
        #1;
        RD = 1'b1;
        cpu_addr = 32'd126;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (expData.size() == 0 && expA1.size() == 0 && modelCount == 0) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput("drain_done", {31'd0, drained}, 32'd1);
        repeat (3) @(negedge Clk);
        checkOutput("end_pops", 32'(popCount), 32'(n));
        checkOutput("end_hht", {31'd0, hht}, 32'd0);
        checkOutput("end_rdata", {27'd0, rdata}, 32'd0);
        checkOutput("end_addr1", addr1, 32'd0);
        checkOutput("end_addr2", addr2, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        bit reached;
        bit resumed;
        logic [31:0] cb;
        logic [31:0] vb;
        logic [31:0] n;

        // Worked example with continuous pops: 205 elements, known first values.
        RD = 1'b1;
        cpu_addr = 32'd126;
        applyStimulus(32'd180, 32'd2, 32'd205, 1'b1);
        @(posedge Clk); #1;
        checkOutput("baseb_regaddr1", {27'd0, regaddr1}, 32'd8);
        checkOutput("baseb_regaddr2", {27'd0, regaddr2}, 32'd9);
        @(posedge Clk); #1;
        checkOutput("first_addr1", addr1, 32'd180);
        @(posedge Clk); #1;
        checkOutput("first_addr2", addr2, 32'd9);
        checkOutput("hht_before_push", {31'd0, hht}, 32'd0);
        @(posedge Clk); #1;
        checkOutput("hht_after_push", {31'd0, hht}, 32'd1);
        checkOutput("first_entry", headValue(), 32'd8);
        @(posedge Clk); #1;
        checkOutput("second_entry", headValue(), 32'd84);
        @(posedge Clk); #1;
        checkOutput("third_entry", headValue(), 32'd54);
        finishRun(205, 400);

        // No pops: FIFO fills, issue stalls, then resumes once popping starts.
        RD = 1'b1;
        cpu_addr = 32'd0;
        applyStimulus(32'($urandom_range(1000, 90000)), 32'($urandom_range(1, 40)), 32'd30, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            if (rdata == 5'd9) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("fill_reached", {31'd0, reached}, 32'd1);
        repeat (3) begin
            @(negedge Clk);
            checkOutput("stall_addr1", addr1, 32'd0);
            checkOutput("stall_rdata", {27'd0, rdata}, 32'd9);
        end
        @(posedge Clk); #1;
        cpu_addr = 32'd126;
        resumed = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (addr1 != 32'd0) resumed = 1'b1;
        end
        checkOutput("issue_resumed", {31'd0, resumed}, 32'd1);
        finishRun(30, 200);

        // Zero-length job never touches memory.
        applyStimulus(32'd500, 32'd3, 32'd0, 1'b0);
        repeat (12) begin
            @(negedge Clk);
            checkOutput("zero_job_access", addr1 | addr2, 32'd0);
        end
        finishRun(0, 20);

        // Reset in the middle of a run with entries buffered, then a clean restart.
        RD = 1'b1;
        cpu_addr = 32'd0;
        cb = 32'($urandom_range(1000, 90000));
        vb = 32'($urandom_range(1, 40));
        applyStimulus(cb, vb, 32'd50, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (rdata == 5'd5) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("five_buffered", {31'd0, reached}, 32'd1);
        #2 Rst = 1'b0;
        #1;
        checkOutput("midrst_hht", {31'd0, hht}, 32'd0);
        checkOutput("midrst_rdata", {27'd0, rdata}, 32'd0);
        checkOutput("midrst_adata", {27'd0, adata}, 32'd0);
        cpu_addr = 32'd126;
        applyStimulus(cb, vb, 32'd20, 1'b0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        checkOutput("restart_addr1", addr1, cb);
        finishRun(20, 200);

        // Random jobs with irregular CPU read traffic.
        for (int r = 0; r < 3; r++) begin
            cb = 32'($urandom_range(1000, 90000));
            vb = 32'($urandom_range(1, 40));
            n  = 32'($urandom_range(1, 40));
            applyStimulus(cb, vb, n, 1'b0);
            repeat (50) begin
                @(posedge Clk); #1;
                RD = 1'($urandom_range(0, 1));
                cpu_addr = ($urandom_range(0, 3) != 0) ? 32'd126 : 32'($urandom_range(0, 200));
            end
            finishRun(int'(n), 300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
